// File: rtl/textbox_ctrl.sv
// -----------------------------------------------------------------------------
// textbox_ctrl
// Character-cell write controller for a single-line textbox display.
// A writer streams bytes into a shadow buffer through a valid/ready handshake.
// Printable bytes are written at the cursor. A small set of control bytes
// behave as follows:
//   0x08  backspace
//   0x0D  carriage return
//   0x0C  form feed (clear)
//   0x0A  line feed (commit)
// On a commit, the shadow buffer is copied to the displayed cells on the next
// frame boundary, so the display never shows a half-written line.
//
// Ports
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   in_data      : byte offered by the writer
//   in_valid     : in_data valid
//   in_ready     : controller accepts a byte this cycle (state is IDLE)
//   frame_start  : one-cycle pulse at the start of each display frame
//   chars        : committed cells shown by the textbox
//   cursor       : current write column
//   dirty        : shadow buffer differs (or may differ) from chars
//   commit_done  : one-cycle pulse, high the cycle after chars updates
// -----------------------------------------------------------------------------
module textbox_ctrl #(
    parameter int COLS  = 8,
    parameter int XBITS = $clog2(COLS*8)-1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             frame_start,
    output logic [7:0]       chars [COLS-1:0],
    output logic [XBITS-3:0] cursor,
    output logic             dirty,
    output logic             commit_done
);

    localparam int            CW       = XBITS-2;
    localparam logic [CW-1:0] LAST_COL = CW'(COLS-1);
    localparam logic [7:0]    SPACE    = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cursor_q, cursor_d;
    logic [CW-1:0] clr_idx_q, clr_idx_d;
    logic [7:0]    shadow_q [COLS-1:0];
    logic [7:0]    shadow_d [COLS-1:0];
    logic [7:0]    chars_q  [COLS-1:0];
    logic          dirty_q, dirty_d;
    logic          commit_done_q;
    logic          accept_s;
    logic          commit_fire_s;
    logic [CW-1:0] bs_col_s;

    // True for the printable ASCII range that is stored as a character.
    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

    // Handshake: the controller only listens while idle.
    assign in_ready = (state_q == ST_IDLE);
    assign accept_s = in_valid && (state_q == ST_IDLE);

    // Backspace target column, saturating at column 0.
    assign bs_col_s = (cursor_q == {CW{1'b0}}) ? {CW{1'b0}} : (cursor_q - CW'(1));

    // Next-state logic for the FSM, cursor, shadow buffer and dirty flag.
    always_comb begin
        state_d       = state_q;
        cursor_d      = cursor_q;
        clr_idx_d     = clr_idx_q;
        shadow_d      = shadow_q;
        dirty_d       = dirty_q;
        commit_fire_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (is_printable(in_data)) begin
                        shadow_d[cursor_q] = in_data;
                        dirty_d            = 1'b1;
                        cursor_d           = (cursor_q == LAST_COL) ? {CW{1'b0}}
                                                                    : (cursor_q + CW'(1));
                    end else begin
                        case (in_data)
                            8'h08: begin
                                cursor_d           = bs_col_s;
                                shadow_d[bs_col_s] = SPACE;
                                dirty_d            = 1'b1;
                            end
                            8'h0D: cursor_d = {CW{1'b0}};
                            8'h0C: begin
                                state_d   = ST_CLEAR;
                                clr_idx_d = {CW{1'b0}};
                                cursor_d  = {CW{1'b0}};
                                dirty_d   = 1'b1;
                            end
                            8'h0A: state_d = ST_COMMIT;
                            default: state_d = ST_IDLE;
                        endcase
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                // One cell per cycle, ascending; leave after the last column.
                shadow_d[clr_idx_q] = SPACE;
                if (clr_idx_q == LAST_COL) begin
                    state_d   = ST_IDLE;
                    clr_idx_d = {CW{1'b0}};
                end else begin
                    clr_idx_d = clr_idx_q + CW'(1);
                end
            end
            ST_COMMIT: begin
                // The frame pulse is only honoured once we are already waiting,
                // so a pulse coinciding with the 0x0A byte is skipped.
                if (frame_start) begin
                    commit_fire_s = 1'b1;
                    dirty_d       = 1'b0;
                    state_d       = ST_IDLE;
                end else begin
                    state_d = ST_COMMIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; chars copies the whole shadow atomically.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cursor_q      <= {CW{1'b0}};
            clr_idx_q     <= {CW{1'b0}};
            dirty_q       <= 1'b0;
            commit_done_q <= 1'b0;
            for (int i = 0; i < COLS; i++) begin
                shadow_q[i] <= SPACE;
                chars_q[i]  <= SPACE;
            end
        end else begin
            state_q       <= state_d;
            cursor_q      <= cursor_d;
            clr_idx_q     <= clr_idx_d;
            dirty_q       <= dirty_d;
            commit_done_q <= commit_fire_s;
            for (int i = 0; i < COLS; i++) begin
                shadow_q[i] <= shadow_d[i];
                if (commit_fire_s) begin
                    chars_q[i] <= shadow_q[i];
                end else begin
                    chars_q[i] <= chars_q[i];
                end
            end
        end
    end

    assign chars       = chars_q;
    assign cursor      = cursor_q;
    assign dirty       = dirty_q;
    assign commit_done = commit_done_q;

endmodule

// File: tb/tb_textbox_ctrl.sv
// -----------------------------------------------------------------------------
// tb_textbox_ctrl
// Directed stimulus for textbox_ctrl (COLS = 8). Every commit pushes the
// hand-computed display image and cursor into a queue; a monitor pops one entry
// on each commit_done pulse and compares. The monitor also flags any change of
// chars that is not accompanied by commit_done while out of reset.
// -----------------------------------------------------------------------------
module tb_textbox_ctrl;

    localparam int COLS = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       frame_start = 1'b0;
    logic [7:0] chars [COLS-1:0];
    logic [2:0] cursor;
    logic       dirty;
    logic       commit_done;

    typedef struct packed {
        logic [63:0] ch;
        logic [2:0]  cur;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    textbox_ctrl #(.COLS(COLS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .frame_start(frame_start),
        .chars      (chars),
        .cursor     (cursor),
        .dirty      (dirty),
        .commit_done(commit_done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pack_chars();
        logic [63:0] p;
        for (int i = 0; i < COLS; i++) p[i*8 +: 8] = chars[i];
        return p;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pop on commit_done, and guard against stray chars changes.
    logic [63:0] prev_pk;
    logic        prev_valid = 1'b0;
    logic        prev_cd    = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_cd    = 1'b0;
        end else begin
            if (commit_done) begin
                chk("cd_single_pulse", {63'd0, prev_cd}, 64'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_commit_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("commit_chars", pack_chars(), e.ch);
                    chk("commit_cursor", {61'd0, cursor}, {61'd0, e.cur});
                    chk("commit_dirty", {63'd0, dirty}, 64'd0);
                end
            end else if (prev_valid) begin
                chk("chars_stable", pack_chars(), prev_pk);
            end else begin
                prev_cd = 1'b0;
            end
            prev_pk    = pack_chars();
            prev_valid = 1'b1;
            prev_cd    = commit_done;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("send_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
    endtask

    task automatic commit_expect(input logic [63:0] ch, input logic [2:0] cur);
        exp_t e;
        e.ch  = ch;
        e.cur = cur;
        exp_q.push_back(e);
        send_byte(8'h0A);
        repeat (2) @(negedge clk);
        pulse_frame();
        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        chk({tag, "_cursor"}, {61'd0, cursor}, 64'd0);
        chk({tag, "_dirty"}, {63'd0, dirty}, 64'd0);
        chk({tag, "_commit_done"}, {63'd0, commit_done}, 64'd0);
        chk({tag, "_chars"}, pack_chars(), 64'h2020_2020_2020_2020);
    endtask

    initial begin
        int n;
        // Reset: a valid byte during reset must not be taken.
        in_data  = 8'h5A;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        in_valid = 1'b0;
        rst_n    = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_no_accept_cursor", {61'd0, cursor}, 64'd0);
        chk("rst_no_accept_dirty", {63'd0, dirty}, 64'd0);

        // "AB" then commit.
        send_byte(8'h41);
        send_byte(8'h42);
        chk("ab_cursor", {61'd0, cursor}, 64'd2);
        chk("ab_dirty", {63'd0, dirty}, 64'd1);
        commit_expect(64'h2020_2020_2020_4241, 3'd2);
        chk("ab_in_ready_idle", {63'd0, in_ready}, 64'd1);

        // Nine bytes wrap the cursor.
        do_reset();
        for (int i = 0; i < 9; i++) send_byte(8'h61 + 8'(i));
        chk("wrap_cursor", {61'd0, cursor}, 64'd1);
        commit_expect(64'h6867_6665_6463_6269, 3'd1);

        // Backspace saturates at column 0.
        do_reset();
        send_byte(8'h58);
        send_byte(8'h59);
        send_byte(8'h08);
        chk("bs1_cursor", {61'd0, cursor}, 64'd1);
        send_byte(8'h08);
        send_byte(8'h08);
        chk("bs3_cursor", {61'd0, cursor}, 64'd0);
        chk("bs_dirty", {63'd0, dirty}, 64'd1);
        commit_expect(64'h2020_2020_2020_2020, 3'd0);

        // CR, ignored bytes, and the top printable boundary.
        send_byte(8'h43);
        send_byte(8'h44);
        send_byte(8'h0D);
        chk("cr_cursor", {61'd0, cursor}, 64'd0);
        send_byte(8'h45);
        send_byte(8'h01);
        send_byte(8'h7F);
        send_byte(8'h1F);
        chk("ignored_cursor", {61'd0, cursor}, 64'd1);
        send_byte(8'h7E);
        commit_expect(64'h2020_2020_2020_7E45, 3'd2);

        // Clear takes COLS cycles; a held 'Q' lands in cell 0 afterwards.
        send_byte(8'h0C);
        @(negedge clk);
        in_data     = 8'h51;
        in_valid    = 1'b1;
        frame_start = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        frame_start = 1'b0;
        chk("clear_busy_cycles", 64'(n), 64'd8);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("clear_q_cursor", {61'd0, cursor}, 64'd1);
        chk("clear_dirty", {63'd0, dirty}, 64'd1);
        commit_expect(64'h2020_2020_2020_2051, 3'd1);

        // frame_start coinciding with 0x0A is skipped.
        send_byte(8'h52);
        @(negedge clk);
        in_data     = 8'h0A;
        in_valid    = 1'b1;
        frame_start = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        frame_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("coincide_still_waiting", {63'd0, in_ready}, 64'd0);
        chk("coincide_dirty", {63'd0, dirty}, 64'd1);
        begin
            exp_t e;
            e.ch  = 64'h2020_2020_2020_5251;
            e.cur = 3'd2;
            exp_q.push_back(e);
        end
        pulse_frame();
        repeat (3) @(negedge clk);
        chk("coincide_committed", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of CLEAR.
        send_byte(8'h5A);
        send_byte(8'h0C);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_clear");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of COMMIT, racing a frame pulse.
        send_byte(8'h4B);
        send_byte(8'h0A);
        repeat (2) @(negedge clk);
        frame_start = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_commit");
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_abort_chars", pack_chars(), 64'h2020_2020_2020_2020);
        chk("post_abort_dirty", {63'd0, dirty}, 64'd0);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/textbox_ctrl.md
TEXTBOX_CTRL -- requirements
Module: textbox_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 8, the number of character cells (legal range 2..64).
REQ-002 SHALL have parameter XBITS, default $clog2(COLS*8)-1, used only for the cursor width rule in REQ-013.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_data  input  8  byte offered by the writer.
REQ-006 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-007 SHALL have port in_ready  output  1  the controller accepts a byte this cycle.
REQ-008 SHALL have port frame_start  input  1  one-cycle pulse at the start of each display frame.
REQ-009 SHALL have port chars  output  8 x COLS (unpacked [COLS-1:0])  committed cells, driving the textbox chars input.
REQ-010 SHALL have port cursor  output  XBITS-2 bits  current write column.
REQ-011 SHALL have port dirty  output  1  the shadow buffer differs from chars, or may differ, since the last commit.
REQ-012 SHALL have port commit_done  output  1  one-cycle pulse on the cycle after chars is updated.

Function
REQ-013 SHALL hold a shadow buffer of COLS 8-bit cells and a cursor of XBITS-2 bits, range 0..COLS-1.
REQ-014 SHALL implement states IDLE, CLEAR and COMMIT; in_ready = 1 exactly when state is IDLE (combinational).
REQ-015 SHALL accept a byte on any cycle where in_valid and in_ready are both 1; the bench may hold in_data/in_valid while in_ready is 0.
REQ-016 Accepted 0x20..0x7E SHALL write shadow[cursor] = byte, set dirty = 1, and advance cursor; COLS-1 wraps to 0; the state stays IDLE.
REQ-017 Accepted 0x08 SHALL decrement cursor, saturating at 0, write 0x20 into shadow at the new cursor, and set dirty = 1.
REQ-018 Accepted 0x0D SHALL set cursor = 0 with no buffer change.
REQ-019 Accepted 0x0C SHALL enter CLEAR:
  - one cell per cycle is written with 0x20, indices 0..COLS-1 ascending, over exactly COLS cycles;
  - cursor = 0 and dirty = 1;
  - the state then returns to IDLE.
REQ-020 Accepted 0x0A SHALL enter COMMIT:
  - on the first later cycle with frame_start = 1, chars = shadow (all cells together) and dirty = 0;
  - the state returns to IDLE and commit_done pulses on the following cycle.
REQ-021 If frame_start coincides with acceptance of 0x0A, it SHALL NOT commit; the commit waits for the next frame_start.
REQ-022 frame_start in IDLE or CLEAR SHALL be ignored; chars SHALL change only per REQ-020.
REQ-023 Any other accepted byte SHALL be consumed with no effect.
REQ-024 The shadow and cursor SHALL be unchanged while in COMMIT; the shadow SHALL be unchanged in CLEAR except for the cells written by REQ-019.

Reset
REQ-025 While rst_n = 0:
  - state = IDLE;
  - all shadow and chars cells = 0x20;
  - cursor = 0, dirty = 0, commit_done = 0;
  - in_ready reads 1 but no byte is accepted.
REQ-026 Reset asserted during CLEAR or COMMIT SHALL abort the operation immediately; no partial commit is allowed.

Verification
REQ-027 After reset, send "AB", 0x0A, then frame_start:
  - chars[0] = 0x41, chars[1] = 0x42, other cells 0x20;
  - commit_done pulses one cycle after the update;
  - cursor = 2, dirty = 0.
REQ-028 With COLS = 8, send 9 bytes 'a'..'i', then commit:
  - chars[0] = 'i', chars[1..7] = 'b'..'h';
  - cursor = 1.
REQ-029 Send "XY", 0x08, 0x08, 0x08, 0x0A, then commit:
  - chars[0] = chars[1] = 0x20;
  - cursor = 0.
REQ-030 Send 0x0C followed by 'Q' held valid:
  - in_ready = 0 for exactly COLS cycles;
  - 'Q' is accepted on the first IDLE cycle and lands in shadow[0].
REQ-031 Send 0x0A with frame_start in the same cycle:
  - no commit on that cycle;
  - commit occurs on the next frame_start pulse.
REQ-032 Deassert rst_n mid-CLEAR and mid-COMMIT:
  - outputs return to the REQ-025 values asynchronously;
  - no commit_done pulse follows.
